spike_encoder: RTL

Rate-codes a frame of multi-bit input intensities into per-channel spike trains that drive the spike-input bus of the neuron array. Each channel runs a first-order sigma-delta accumulator, so a channel value v yields floor(v·WINDOW/2^WIDTH) spikes per frame. The block is the producing end of the spike interface the neuron consumes. It also emits the learn strobe, gated to active frames.

---
 rtl/spike_encoder_pkg.sv | 13 +
 rtl/spike_encoder_if.sv | 29 ++
 rtl/spike_encoder_channel.sv | 30 +++
 rtl/spike_encoder.sv | 113 +++++++++++
 4 files changed

// File: rtl/spike_encoder_pkg.sv
// Shared constants and FSM encoding for the spike encoder slice.
package spike_encoder_pkg;

  localparam int DEF_CHANNELS = 8;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_WINDOW   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/spike_encoder_if.sv
// Host-write / spike-bus bundle between the encoder (master) and its host + neuron array (slave).
interface spike_encoder_if
  import spike_encoder_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int WIDTH    = DEF_WIDTH
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                wr_en;
  logic [CH_W-1:0]     wr_chan;
  logic [WIDTH-1:0]    wr_value;
  logic                start;
  logic                learn_en;
  logic [0:CHANNELS-1] spikes;
  logic                learn;
  logic                busy;
  logic                frame_done;

  modport master (
    input  wr_en, wr_chan, wr_value, start, learn_en,
    output spikes, learn, busy, frame_done
  );

  modport slave (
    output wr_en, wr_chan, wr_value, start, learn_en,
    input  spikes, learn, busy, frame_done
  );
endinterface

// File: rtl/spike_encoder_channel.sv
// One first-order sigma-delta channel: phase accumulates value each enabled cycle, carry-out is the spike.
// The spike is registered and drops to 0 on any cycle without an add.
module spike_encoder_channel #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] value,
  output logic             spike
);

  logic [WIDTH-1:0] phase;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
      spike <= 1'b0;
    end else if (clear) begin
      phase <= '0;
      spike <= 1'b0;
    end else if (enable) begin
      {spike, phase} <= {1'b0, phase} + {1'b0, value};
    end else begin
      spike <= 1'b0;
    end
  end

endmodule

// File: rtl/spike_encoder.sv
// Rate-codes a frame of per-channel intensities into WINDOW cycles of spikes on the neuron spike bus.
// Shadow bank is host-written at any time; active bank is frozen when a frame starts.
module spike_encoder
  import spike_encoder_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int WINDOW   = DEF_WINDOW
) (
  input logic              clk,
  input logic              reset,
  spike_encoder_if.master  bus
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                cnt_last;
  logic                load;
  logic                add;
  logic                last;
  logic                busy;
  logic                learn;
  logic                frame_done;
  logic [WIDTH-1:0]    shadow [CHANNELS];
  logic [WIDTH-1:0]    active [CHANNELS];
  logic [0:CHANNELS-1] spk;

  assign cnt_last = (cnt == CNT_W'(WINDOW - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load = 1'b0;
    add  = 1'b0;
    last = 1'b0;
    busy = 1'b0;
    case (state)
      IDLE: load = bus.start;
      RUN: begin
        add  = 1'b1;
        busy = 1'b1;
        last = cnt_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      learn      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last;
      if (load) begin
        cnt   <= '0;
        learn <= bus.learn_en;
      end else if (add) begin
        cnt <= cnt + 1'b1;
        if (last) learn <= 1'b0;
      end
    end
  end

  // Index decode compares against each real channel, so indices >= CHANNELS match nothing.
  // Active samples shadow through a non-blocking read, so a same-cycle write only reaches shadow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.wr_en && (bus.wr_chan == CH_W'(i))) shadow[i] <= bus.wr_value;
        if (load) active[i] <= shadow[i];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    spike_encoder_channel #(.WIDTH(WIDTH)) u_ch (
      .clk    (clk),
      .reset  (reset),
      .clear  (load),
      .enable (add),
      .value  (active[g]),
      .spike  (spk[g])
    );
  end

  assign bus.spikes     = spk;
  assign bus.learn      = learn;
  assign bus.busy       = busy;
  assign bus.frame_done = frame_done;

endmodule
